// File: rtl/mono_packet_pkg.sv
// Shared types and defaults for the mono-sample to stereo-packet transmitter.
// Defines the FSM state type, default widths and the packet length.
package mono_packet_pkg;

    localparam int DATA_WIDTH_DEF   = 32;
    localparam int FIFO_DEPTH_DEF   = 4;
    localparam int BEATS_PER_PACKET = 2;

    typedef enum logic [1:0] {
        IDLE,
        SEND_LEFT,
        SEND_RIGHT
    } state_t;

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous FIFO for mono samples; head is visible combinationally.
// Simultaneous push and pop are both honoured, leaving the count unchanged.
module sample_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    assign rdata = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mono_sample_to_packet_converter.sv
// Buffers mono samples and emits each as a left/right AXI4-Stream packet.
// Both beats carry the same value; TLAST marks the right beat.
module mono_sample_to_packet_converter
    import mono_packet_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                  M_AXIS_ACLK,
    input  logic                  M_AXIS_ARESETN,
    input  logic                  mono_sample_valid,
    input  logic [DATA_WIDTH-1:0] mono_sample,
    output logic                  M_AXIS_TVALID,
    output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic                  M_AXIS_TLAST,
    input  logic                  M_AXIS_TREADY,
    output logic                  overflow
);

    state_t                state;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] head;
    logic                  pop;
    logic                  push;

    // Pop only when the hold register is free or about to be freed.
    assign pop = !fifo_empty &&
                 ((state == IDLE) ||
                  (state == SEND_RIGHT && M_AXIS_TREADY));

    assign push = mono_sample_valid && (!fifo_full || pop);

    sample_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (M_AXIS_ACLK),
        .rst_n (M_AXIS_ARESETN),
        .push  (push),
        .wdata (mono_sample),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // TDATA doubles as the hold register for the sample in flight.
    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            state         <= IDLE;
            M_AXIS_TVALID <= 1'b0;
            M_AXIS_TLAST  <= 1'b0;
            M_AXIS_TDATA  <= '0;
            overflow      <= 1'b0;
        end else begin
            overflow <= mono_sample_valid && !push;
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        M_AXIS_TDATA  <= head;
                        M_AXIS_TVALID <= 1'b1;
                        M_AXIS_TLAST  <= 1'b0;
                        state         <= SEND_LEFT;
                    end
                end
                SEND_LEFT: begin
                    if (M_AXIS_TREADY) begin
                        M_AXIS_TLAST <= 1'b1;
                        state        <= SEND_RIGHT;
                    end
                end
                SEND_RIGHT: begin
                    if (M_AXIS_TREADY) begin
                        M_AXIS_TLAST <= 1'b0;
                        if (pop) begin
                            M_AXIS_TDATA <= head;
                            state        <= SEND_LEFT;
                        end else begin
                            M_AXIS_TVALID <= 1'b0;
                            state         <= IDLE;
                        end
                    end
                end
                default: begin
                    M_AXIS_TVALID <= 1'b0;
                    M_AXIS_TLAST  <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mono_sample_to_packet_converter.sv
// Scoreboard bench: stimulus queues expected samples, a monitor re-forms
// packets like a stereo-to-mono receiver and compares them in order.
module tb_mono_sample_to_packet_converter;
    import mono_packet_pkg::*;

    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          valid = 1'b0;
    logic [DW-1:0] sample = '0;
    logic          tvalid;
    logic [DW-1:0] tdata;
    logic          tlast;
    logic          tready = 1'b0;
    logic          overflow;

    mono_sample_to_packet_converter #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .M_AXIS_ACLK       (clk),
        .M_AXIS_ARESETN    (rst_n),
        .mono_sample_valid (valid),
        .mono_sample       (sample),
        .M_AXIS_TVALID     (tvalid),
        .M_AXIS_TDATA      (tdata),
        .M_AXIS_TLAST      (tlast),
        .M_AXIS_TREADY     (tready),
        .overflow          (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int hs_count = 0;
    int ovf_count = 0;
    logic [DW-1:0] exp_q[$];

    logic          have_left = 1'b0;
    logic [DW-1:0] left_val = '0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Receiver-side monitor: pairs beats into mono samples.
    always @(negedge clk) begin
        if (!rst_n) begin
            have_left  = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (overflow) ovf_count++;
            if (prev_stall) begin
                check("stall_valid", 64'(tvalid), 64'd1);
                check("stall_data", 64'(tdata), 64'(prev_data));
                check("stall_last", 64'(tlast), 64'(prev_last));
            end
            if (tvalid && tready) begin
                hs_count++;
                if (!have_left) begin
                    check("left_tlast", 64'(tlast), 64'd0);
                    left_val  = tdata;
                    have_left = 1'b1;
                end else begin
                    check("right_tlast", 64'(tlast), 64'd1);
                    check("right_eq_left", 64'(tdata), 64'(left_val));
                    have_left = 1'b0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_packet: got %0h expected none",
                                 tdata);
                    end else begin
                        check("packet_data", 64'(tdata), 64'(exp_q.pop_front()));
                    end
                end
            end
            prev_stall = tvalid && !tready;
            prev_data  = tdata;
            prev_last  = tlast;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write(input logic [DW-1:0] d, input bit accepted);
        valid  = 1'b1;
        sample = d;
        if (accepted) exp_q.push_back(d);
        tick(1);
        valid = 1'b0;
    endtask

    task automatic wait_tvalid(input string name);
        int budget = 20;
        while (!tvalid && budget > 0) begin
            tick(1);
            budget--;
        end
        if (!tvalid) begin
            checks++;
            errors++;
            $display("FAIL %s: got timeout expected tvalid", name);
        end
    endtask

    task automatic drain(input string name);
        int budget = 200;
        tready = 1'b1;
        while ((exp_q.size() != 0 || tvalid) && budget > 0) begin
            tick(1);
            budget--;
        end
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    logic [DW-1:0] d;
    int ovf0;
    int hs0;
    int run;
    bit low_prev;

    initial begin
        // Reset state
        tick(2);
        check("rst_tvalid", 64'(tvalid), 64'd0);
        check("rst_tlast", 64'(tlast), 64'd0);
        check("rst_tdata", 64'(tdata), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        rst_n = 1'b1;
        tick(2);

        // Single sample, latency and beat shape
        tready = 1'b1;
        write(32'h0000_1234, 1'b1);
        @(negedge clk);
        check("lat_n_tvalid", 64'(tvalid), 64'd0);
        @(negedge clk);
        check("lat_n1_tvalid", 64'(tvalid), 64'd1);
        check("lat_n1_tlast", 64'(tlast), 64'd0);
        check("lat_n1_tdata", 64'(tdata), 64'h1234);
        @(negedge clk);
        check("lat_n2_tvalid", 64'(tvalid), 64'd1);
        check("lat_n2_tlast", 64'(tlast), 64'd1);
        check("lat_n2_tdata", 64'(tdata), 64'h1234);
        @(negedge clk);
        check("lat_n3_tvalid", 64'(tvalid), 64'd0);
        @(posedge clk);
        #1;
        drain("single_drain");

        // Backpressure: 5 stalled cycles per beat
        tready = 1'b0;
        hs0 = hs_count;
        write(32'hA5A5_A5A5, 1'b1);
        wait_tvalid("bp_tvalid");
        tick(5);
        tready = 1'b1;
        tick(1);
        tready = 1'b0;
        tick(5);
        tready = 1'b1;
        tick(1);
        tready = 1'b0;
        tick(3);
        check("bp_handshakes", 64'(hs_count - hs0), 64'd2);
        check("bp_queue", 64'(exp_q.size()), 64'd0);

        // Burst of 8 with sink stalled: hold + DEPTH accepted, rest dropped
        ovf0 = ovf_count;
        for (int i = 1; i <= 8; i++) begin
            write(DW'(i), i <= DEPTH + 1);
        end
        tick(1);
        check("burst_overflow", 64'(ovf_count - ovf0), 64'd3);

        // Push and pop on the same edge while full, 3 wraps of the FIFO
        ovf0 = ovf_count;
        for (int i = 0; i < 3 * DEPTH; i++) begin
            tready = 1'b1;
            tick(1);
            write(32'h100 + DW'(i), 1'b1);
            tready = 1'b0;
        end
        tick(1);
        check("full_pushpop_ovf", 64'(ovf_count - ovf0), 64'd0);

        // Remaining DEPTH+1 packets leave back-to-back with no bubble
        tready = 1'b1;
        run = 0;
        @(negedge clk);
        while (tvalid && run < 40) begin
            run++;
            @(negedge clk);
        end
        check("burst_no_bubble", 64'(run), 64'((DEPTH + 1) * BEATS_PER_PACKET));
        @(posedge clk);
        #1;
        drain("burst_drain");

        // Reset while stalled on the right beat
        tready = 1'b0;
        write(32'hDEAD_BEEF, 1'b0);
        wait_tvalid("rst_mid_tvalid");
        tready = 1'b1;
        tick(1);
        tready = 1'b0;
        tick(2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_tvalid", 64'(tvalid), 64'd0);
        check("async_rst_tlast", 64'(tlast), 64'd0);
        check("async_rst_tdata", 64'(tdata), 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tready = 1'b1;
        write(32'h0000_CAFE, 1'b1);
        tick(1);
        write(32'h0000_F00D, 1'b1);
        drain("post_rst_drain");

        // Loopback: 2000 random samples, one write per 4 cycles
        ovf0 = ovf_count;
        low_prev = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            d = $urandom & 32'h7FFF_FFFF;
            tready = low_prev ? 1'b1 : ($urandom_range(0, 3) != 0);
            low_prev = !tready;
            write(d, 1'b1);
            for (int k = 0; k < 3; k++) begin
                tready = low_prev ? 1'b1 : ($urandom_range(0, 3) != 0);
                low_prev = !tready;
                tick(1);
            end
        end
        drain("loop_drain");
        check("loop_overflow", 64'(ovf_count - ovf0), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
